// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers for the MonitorVGA display path.
// Both the sync generator and the downstream pixel generator import this package.
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV   = 2;
    localparam int unsigned VGA_CNT_W     = 10;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // SYNC_POL value selecting active-low sync pulses.
    localparam bit SYNC_ACTIVE_LOW = 1'b0;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } vga_ctrl_t;

    // Drive a sync line to its active level inside the window, idle level outside.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with a combinational wrap strobe; used as the pixel-tick divider.
module mod_n_counter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // With N=1 the count stays at 0 and wrap simply follows enable.
    assign wrap = enable && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, coupled h/v position counters and
// registered sync/blanking strobes aligned with the coordinates they describe.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW,
    parameter int unsigned CNT_W     = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             pix_tick,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam vga_ctrl_t CTRL_RESET = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0};

    logic [DIV_W-1:0] div_count;
    logic             tick;
    logic             unused_div;

    logic [CNT_W-1:0] x_d;
    logic [CNT_W-1:0] y_d;
    vga_ctrl_t        ctrl_d;
    vga_ctrl_t        ctrl_q;
    logic             frame_start_d;

    mod_n_counter #(
        .N (CLK_DIV),
        .W (DIV_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (div_count),
        .wrap   (tick)
    );

    // Only the wrap strobe matters here; the phase itself is not consumed.
    assign unused_div = ^div_count;

    always_comb begin
        x_d = pixel_x;
        y_d = pixel_y;
        if (tick) begin
            if (pixel_x == H_LAST) begin
                x_d = '0;
                y_d = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                x_d = pixel_x + 1'b1;
            end
        end
    end

    // Decode from next-state coordinates so the registered strobes line up with them.
    always_comb begin
        ctrl_d.hsync    = sync_level((x_d >= HS_START) && (x_d <= HS_END), SYNC_POL);
        ctrl_d.vsync    = sync_level((y_d >= VS_START) && (y_d <= VS_END), SYNC_POL);
        ctrl_d.video_on = (x_d < H_VIS) && (y_d < V_VIS);
        frame_start_d   = tick && (x_d == '0) && (y_d == '0);
    end

    // Reset parks on the last blank pixel so the first tick opens a clean frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x     <= H_LAST;
            pixel_y     <= V_LAST;
            ctrl_q      <= CTRL_RESET;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_d;
            pixel_y     <= y_d;
            ctrl_q      <= ctrl_d;
            pix_tick    <= tick;
            frame_start <= frame_start_d;
        end
    end

    assign hsync    = ctrl_q.hsync;
    assign vsync    = ctrl_q.vsync;
    assign video_on = ctrl_q.video_on;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default 640x480 instance plus a tiny-frame
// instance (odd divider, active-high sync) so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [9:0] px;
    logic [9:0] py;
    logic       hs, vs, vo, tk, fs;

    logic       s_reset;
    logic       s_enable;
    logic [3:0] s_x;
    logic [3:0] s_y;
    logic       s_hs, s_vs, s_vo, s_tk, s_fs;

    int checks;
    int failures;
    int cur;

    typedef struct {
        int n;
        int x;
        int y;
        int hs;
        int vs;
        int vo;
        int tk;
        int fs;
    } vec_t;

    vec_t vecs[15];

    vga_sync_gen u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pixel_x     (px),
        .pixel_y     (py),
        .hsync       (hs),
        .vsync       (vs),
        .video_on    (vo),
        .pix_tick    (tk),
        .frame_start (fs)
    );

    vga_sync_gen #(
        .CLK_DIV   (3),
        .H_VISIBLE (4),
        .H_FRONT   (1),
        .H_SYNC    (2),
        .H_BACK    (1),
        .V_VISIBLE (3),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1),
        .SYNC_POL  (1'b1),
        .CNT_W     (4)
    ) u_small (
        .clk         (clk),
        .reset       (s_reset),
        .enable      (s_enable),
        .pixel_x     (s_x),
        .pixel_y     (s_y),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_vo),
        .pix_tick    (s_tk),
        .frame_start (s_fs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input int x, input int y, input int h,
                              input int v, input int o, input int t, input int f);
        check({tag, ".pixel_x"}, 32'(px), 32'(x));
        check({tag, ".pixel_y"}, 32'(py), 32'(y));
        check({tag, ".hsync"}, 32'(hs), 32'(h));
        check({tag, ".vsync"}, 32'(vs), 32'(v));
        check({tag, ".video_on"}, 32'(vo), 32'(o));
        check({tag, ".pix_tick"}, 32'(tk), 32'(t));
        check({tag, ".frame_start"}, 32'(fs), 32'(f));
    endtask

    initial begin
        int fs_first;
        int fs_second;
        int vs_clks;
        int hs_low;
        int vo_hi;
        bit found;
        logic [12:0] s_exp;

        clk      = 1'b0;
        reset    = 1'b0;
        enable   = 1'b1;
        s_reset  = 1'b0;
        s_enable = 1'b1;
        checks   = 0;
        failures = 0;

        // Reset held with enable high: both instances stay parked.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_main($sformatf("reset_hold[%0d]", i), 799, 524, 1, 1, 0, 0, 0);
            check($sformatf("small_reset_hold[%0d]", i),
                  32'({s_x, s_y, s_hs, s_vs, s_vo, s_tk, s_fs}),
                  32'({4'd7, 4'd5, 5'b00000}));
        end

        // Small instance: 8x6 frame, CLK_DIV=3, against a linear tick model.
        s_reset   = 1'b1;
        fs_first  = -1;
        fs_second = -1;
        vs_clks   = 0;
        for (int n = 1; n <= 300; n++) begin
            int t;
            int pos;
            int ex;
            int ey;
            @(posedge clk);
            #1;
            t = n / 3;
            if (t == 0) begin
                s_exp = {4'd7, 4'd5, 5'b00000};
            end else begin
                pos   = (t - 1) % 48;
                ex    = pos % 8;
                ey    = pos / 8;
                s_exp = {4'(ex), 4'(ey), 1'((ex >= 5) && (ex <= 6)), 1'(ey == 4),
                         1'((ex < 4) && (ey < 3)), 1'(n % 3 == 0),
                         1'((n % 3 == 0) && (pos == 0))};
            end
            check($sformatf("small_frame[n=%0d]", n),
                  32'({s_x, s_y, s_hs, s_vs, s_vo, s_tk, s_fs}), 32'(s_exp));
            if (s_fs) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (n >= 3 && n <= 146 && s_vs) vs_clks++;
        end
        check("small_first_frame_start", 32'(fs_first), 32'd3);
        check("small_frame_period_clks", 32'(fs_second - fs_first), 32'd144);
        check("small_vsync_clks", 32'(vs_clks), 32'd24);

        // Main instance: released between edges, then directed vectors.
        vecs[0]  = '{1,    799, 524, 1, 1, 0, 0, 0};
        vecs[1]  = '{2,    0,   0,   1, 1, 1, 1, 1};
        vecs[2]  = '{3,    0,   0,   1, 1, 1, 0, 0};
        vecs[3]  = '{4,    1,   0,   1, 1, 1, 1, 0};
        vecs[4]  = '{5,    1,   0,   1, 1, 1, 0, 0};
        vecs[5]  = '{1280, 639, 0,   1, 1, 1, 1, 0};
        vecs[6]  = '{1282, 640, 0,   1, 1, 0, 1, 0};
        vecs[7]  = '{1312, 655, 0,   1, 1, 0, 1, 0};
        vecs[8]  = '{1314, 656, 0,   0, 1, 0, 1, 0};
        vecs[9]  = '{1315, 656, 0,   0, 1, 0, 0, 0};
        vecs[10] = '{1504, 751, 0,   0, 1, 0, 1, 0};
        vecs[11] = '{1506, 752, 0,   1, 1, 0, 1, 0};
        vecs[12] = '{1600, 799, 0,   1, 1, 0, 1, 0};
        vecs[13] = '{1602, 0,   1,   1, 1, 1, 1, 0};
        vecs[14] = '{1603, 0,   1,   1, 1, 1, 0, 0};

        reset = 1'b1;
        cur   = 0;
        for (int i = 0; i < 15; i++) begin
            while (cur < vecs[i].n) begin
                @(posedge clk);
                cur++;
            end
            #1;
            check_main($sformatf("vec[n=%0d]", vecs[i].n), vecs[i].x, vecs[i].y, vecs[i].hs,
                       vecs[i].vs, vecs[i].vo, vecs[i].tk, vecs[i].fs);
        end

        // Any 1600 consecutive clocks inside the visible rows span exactly one line.
        hs_low = 0;
        vo_hi  = 0;
        repeat (1600) begin
            @(posedge clk);
            cur++;
            #1;
            if (!hs) hs_low++;
            if (vo) vo_hi++;
        end
        check("line_hsync_low_clks", 32'(hs_low), 32'd192);
        check("line_video_on_clks", 32'(vo_hi), 32'd1280);
        check("line2_pixel_x", 32'(px), 32'd0);
        check("line2_pixel_y", 32'(py), 32'd2);

        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(posedge clk);
            cur++;
            #1;
            if (px == 10'd300 && tk) found = 1'b1;
        end
        check("reach_x300", 32'(found), 32'd1);

        // Freeze one clock into the pixel so one divider phase remains on resume.
        @(posedge clk);
        #1;
        check("pre_freeze_pix_tick", 32'(tk), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("freeze[%0d]", i), 32'({px, py, tk, fs, vo, hs, vs}),
                  32'({10'd300, 10'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}));
        end
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("resume_pixel_x", 32'(px), 32'd301);
        check("resume_pix_tick", 32'(tk), 32'd1);
        @(posedge clk);
        #1;
        check("resume_hold_pixel_x", 32'(px), 32'd301);
        check("resume_hold_pix_tick", 32'(tk), 32'd0);

        // Asynchronous reset between edges, mid-line.
        #3;
        reset = 1'b0;
        #2;
        check_main("async_reset", 799, 524, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_main("async_reset_held", 799, 524, 1, 1, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_main("rerelease_edge1", 799, 524, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_main("rerelease_edge2", 0, 0, 1, 1, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
